otp_access_ctrl: RTL and testbench
==================================

# otp_access_ctrl

Parametrised one-time-password access controller for the home-security door path, the next generation of the fixed-width OTP FSM. It generates a fresh OTP from an internal LFSR on each access request, accepts up to MAX_TRIES entry attempts, drives a timed unlock pulse on success and a timed lockout with alarm on exhaustion. It sits between the keypad/entry front end and the door actuator and siren drivers.

## Interface
- OTP_W, 32: OTP width in bits, 4..32; OTP is the low OTP_W bits of the LFSR.
- MAX_TRIES, 3: wrong attempts allowed per request, 1..15.
- UNLOCK_CYC, 16: cycles `unlock` stays high after a correct entry.
- LOCKOUT_CYC, 64: cycles spent in lockout after the last wrong attempt.
- OTP_TIMEOUT, 1000: cycles an issued OTP stays valid; used only with OTP_EXPIRY_EN.
- SEED, 32'h00013579: LFSR reset value, must be non-zero.
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_access  in  1  access request, level-sampled.
- enter_otp  in  1  entry strobe; only its rising edge counts as an attempt.
- user_entered_otp  in  OTP_W  code presented with enter_otp.
- otp_value  out  OTP_W  issued OTP for the delivery channel.
- otp_valid  out  1  high while otp_value is live.
- correct  out  1  one-cycle pulse, matching attempt.
- wrong  out  1  one-cycle pulse, mismatching attempt.
- unlock  out  1  door release, high for UNLOCK_CYC cycles.
- deny  out  1  high during lockout; one-cycle pulse on OTP expiry.
- alarm  out  1  high during lockout.
- attempts_left  out  4  remaining attempts for the current OTP.

## Operation
- Reset values: state IDLE, LFSR=SEED, otp_value=0, otp_valid=0, correct=wrong=unlock=deny=alarm=0, attempts_left=MAX_TRIES, enter_otp edge register=0.
- LFSR: 32-bit Fibonacci, polynomial x^32+x^22+x^2+x+1, shifts left every cycle in every state.
- Edge detect: attempt = enter_otp & ~enter_otp_d (enter_otp_d registered). Holding enter_otp high gives one attempt only.
- IDLE: req_access=1 -> WAIT_OTP; otp_value <= LFSR[OTP_W-1:0], otp_valid <= 1, attempts_left <= MAX_TRIES. An attempt edge in the same cycle is ignored.
- WAIT_OTP: req_access ignored (no regeneration). On an attempt edge compare user_entered_otp to otp_value:
  - match: correct pulse, unlock <= 1, otp_valid <= 0, -> UNLOCKED.
  - mismatch, attempts_left>1: wrong pulse, attempts_left decrements, stay.
  - mismatch, attempts_left==1: wrong pulse, attempts_left <= 0, otp_valid <= 0, deny <= 1, alarm <= 1, -> LOCKOUT.
- UNLOCKED: counter runs UNLOCK_CYC cycles, then unlock <= 0, -> IDLE. Inputs ignored.
- LOCKOUT: counter runs LOCKOUT_CYC cycles, then deny <= 0, alarm <= 0, attempts_left <= MAX_TRIES, -> IDLE. Inputs ignored.
- An edge arriving in UNLOCKED or LOCKOUT is consumed and never carried into IDLE/WAIT_OTP.
- rst asserted in any state returns all outputs and state to reset values immediately; LFSR restarts at SEED.

## Timing
- All outputs registered. Attempt edge sampled at edge N -> correct/wrong/unlock/deny change at edge N+1 (one-cycle latency).
- req_access sampled at edge N in IDLE -> otp_valid=1 and otp_value stable from edge N+1.
- unlock high for exactly UNLOCK_CYC cycles; alarm/deny high for exactly LOCKOUT_CYC cycles; state IDLE on the following edge; req_access accepted on the next edge after that.
- correct and wrong are never high together; unlock and alarm are never high together.

## Configuration
- OTP_EXPIRY_EN defined: the WAIT_OTP timer clears on entry to WAIT_OTP. If OTP_TIMEOUT cycles pass with no match and no lockout, otp_valid <= 0, deny pulses one cycle, attempts_left <= MAX_TRIES, -> IDLE, alarm stays 0. An attempt edge in the expiry cycle is ignored; expiry wins.
- OTP_EXPIRY_EN undefined: no timer logic; WAIT_OTP waits indefinitely; deny is asserted only by lockout.

## Test plan
- Reset and idle: rst=1 for 2 cycles, then release -> every output at its reset value, attempts_left=3, otp_valid=0.
- Correct entry: req_access, then one enter_otp rising edge with user_entered_otp=otp_value -> correct for 1 cycle at N+1, unlock high 16 cycles, then IDLE.
- Held strobe: enter_otp held high 40 cycles with a wrong code -> exactly one wrong pulse, attempts_left 3->2.
- Lockout: 3 wrong edges (e.g. 32'h000ABCDE) -> wrong pulses, attempts_left 2,1,0; deny=alarm=1 for 64 cycles; req_access ignored during lockout; attempts_left=3 afterwards.
- Expiry (OTP_EXPIRY_EN, OTP_TIMEOUT=20): req_access, no entry -> otp_valid drops and deny pulses 1 cycle at cycle 20; a correct code entered afterwards gives no unlock.
- Mid-operation reset: rst during UNLOCKED at cycle 5 -> unlock falls immediately, state IDLE, LFSR=SEED.

Source files
------------

// File: rtl/otp_access_ctrl.sv
// otp_access_ctrl: LFSR-issued one-time password with retry budget, timed unlock and lockout.
// Define OTP_EXPIRY_EN to give each issued OTP a lifetime of OTP_TIMEOUT cycles.
module otp_access_ctrl #(
  parameter int          OTP_W       = 32,
  parameter int          MAX_TRIES   = 3,
  parameter int          UNLOCK_CYC  = 16,
  parameter int          LOCKOUT_CYC = 64,
  parameter int          OTP_TIMEOUT = 1000,
  parameter logic [31:0] SEED        = 32'h00013579
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_access,
  input  logic             enter_otp,
  input  logic [OTP_W-1:0] user_entered_otp,
  output logic [OTP_W-1:0] otp_value,
  output logic             otp_valid,
  output logic             correct,
  output logic             wrong,
  output logic             unlock,
  output logic             deny,
  output logic             alarm,
  output logic [3:0]       attempts_left
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OTP,
    UNLOCKED,
    LOCKOUT
  } state_t;

  localparam int T_UL  = UNLOCK_CYC > LOCKOUT_CYC ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int T_MAX = OTP_TIMEOUT > T_UL ? OTP_TIMEOUT : T_UL;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam logic [3:0] TRIES = 4'(MAX_TRIES);

  state_t             state, state_n;
  logic [31:0]        lfsr, lfsr_n;
  logic               enter_d;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [OTP_W-1:0]   otp_n;
  logic               valid_n, correct_n, wrong_n;
  logic               unlock_n, deny_n, alarm_n;
  logic [3:0]         left_n;
  logic               attempt, hit;

  assign attempt = enter_otp & ~enter_d;
  assign hit     = user_entered_otp == otp_value;
  assign lfsr_n  = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    otp_n     = otp_value;
    valid_n   = otp_valid;
    correct_n = 1'b0;
    wrong_n   = 1'b0;
    unlock_n  = unlock;
    deny_n    = deny;
    alarm_n   = alarm;
    left_n    = attempts_left;
    unique case (state)
      IDLE: begin
        deny_n = 1'b0;
        cnt_n  = '0;
        if (req_access) begin
          state_n = WAIT_OTP;
          otp_n   = lfsr[OTP_W-1:0];
          valid_n = 1'b1;
          left_n  = TRIES;
        end
      end
      WAIT_OTP: begin
`ifdef OTP_EXPIRY_EN
        if (cnt == CNT_W'(OTP_TIMEOUT - 1)) begin
          state_n = IDLE;
          valid_n = 1'b0;
          deny_n  = 1'b1;
          left_n  = TRIES;
          cnt_n   = '0;
        end else
`endif
        if (attempt) begin
          wrong_n = ~hit;
          if (hit) begin
            correct_n = 1'b1;
            unlock_n  = 1'b1;
            valid_n   = 1'b0;
            cnt_n     = '0;
            state_n   = UNLOCKED;
          end else if (attempts_left > 4'd1) begin
            left_n = attempts_left - 4'd1;
          end else begin
            left_n  = 4'd0;
            valid_n = 1'b0;
            deny_n  = 1'b1;
            alarm_n = 1'b1;
            cnt_n   = '0;
            state_n = LOCKOUT;
          end
        end
      end
      UNLOCKED: begin
        if (cnt == CNT_W'(UNLOCK_CYC - 1)) begin
          unlock_n = 1'b0;
          cnt_n    = '0;
          state_n  = IDLE;
        end
      end
      LOCKOUT: begin
        if (cnt == CNT_W'(LOCKOUT_CYC - 1)) begin
          deny_n  = 1'b0;
          alarm_n = 1'b0;
          left_n  = TRIES;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= SEED;
      enter_d       <= 1'b0;
      cnt           <= '0;
      otp_value     <= '0;
      otp_valid     <= 1'b0;
      correct       <= 1'b0;
      wrong         <= 1'b0;
      unlock        <= 1'b0;
      deny          <= 1'b0;
      alarm         <= 1'b0;
      attempts_left <= TRIES;
    end else begin
      state         <= state_n;
      lfsr          <= lfsr_n;
      enter_d       <= enter_otp;
      cnt           <= cnt_n;
      otp_value     <= otp_n;
      otp_valid     <= valid_n;
      correct       <= correct_n;
      wrong         <= wrong_n;
      unlock        <= unlock_n;
      deny          <= deny_n;
      alarm         <= alarm_n;
      attempts_left <= left_n;
    end
  end

endmodule

// File: tb/tb_otp_access_ctrl.sv
// tb_otp_access_ctrl: randomized OTP sessions, expected events queued by stimulus,
// checked by an independent output monitor.
module tb_otp_access_ctrl;

  localparam int          W      = 32;
  localparam int          TRIES  = 3;
  localparam int          UL     = 16;
  localparam int          LO     = 64;
  localparam int          TO     = 20;
  localparam logic [31:0] SEED   = 32'h00013579;
`ifdef OTP_EXPIRY_EN
  localparam int HOLD_MAX  = 1;
  localparam int GAP_MAX   = 1;
  localparam int HOLD_LONG = 10;
`else
  localparam int HOLD_MAX  = 6;
  localparam int GAP_MAX   = 3;
  localparam int HOLD_LONG = 40;
`endif

  logic         clk = 0;
  logic         rst;
  logic         req_access;
  logic         enter_otp;
  logic [W-1:0] user_entered_otp;
  logic [W-1:0] otp_value;
  logic         otp_valid, correct, wrong, unlock, deny, alarm;
  logic [3:0]   attempts_left;

  otp_access_ctrl #(
    .OTP_W(W), .MAX_TRIES(TRIES), .UNLOCK_CYC(UL),
    .LOCKOUT_CYC(LO), .OTP_TIMEOUT(TO), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .req_access(req_access),
    .enter_otp(enter_otp), .user_entered_otp(user_entered_otp),
    .otp_value(otp_value), .otp_valid(otp_valid),
    .correct(correct), .wrong(wrong), .unlock(unlock),
    .deny(deny), .alarm(alarm), .attempts_left(attempts_left)
  );

  always #5 clk = ~clk;

  typedef enum {
    EV_ISSUE, EV_CORRECT, EV_WRONG, EV_LOCK, EV_EXPIRE,
    EV_UNLOCK_END, EV_LOCK_END, EV_DENY_END
  } ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [31:0] val;
    logic [31:0] aux;
  } ev_t;

  ev_t         sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] cur_otp;

  // posedges since reset release: the OTP sampled at a posedge is SEED stepped cyc times
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic logic [31:0] lfsr_at(input int n);
    logic [31:0] v;
    v = SEED;
    for (int i = 0; i < n; i++)
      v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    return v;
  endfunction

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic void push(input ev_kind_t k, input logic [31:0] v,
                               input logic [31:0] a);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.aux  = a;
    sb.push_back(e);
  endfunction

  task automatic expect_ev(input ev_kind_t k, input logic [31:0] v,
                           input logic [31:0] a);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s got=%0h/%0h want=none t=%0t",
               k.name(), v, a, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val != v || e.aux != a) begin
        bad++;
        $display("FAIL event got=%s %0h/%0h want=%s %0h/%0h t=%0t",
                 k.name(), v, a, e.kind.name(), e.val, e.aux, $time);
      end
    end
  endtask

  logic        pv, pu, pa, pd;
  int          cv, cu, ca, cd;
  logic [31:0] held;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; pu = 0; pa = 0; pd = 0;
        cv = 0; cu = 0; ca = 0; cd = 0;
      end else begin
        if (otp_valid && !pv) expect_ev(EV_ISSUE, otp_value, 0);
        if (otp_valid && pv) chk("otp_stable", otp_value, held);
        if (correct) expect_ev(EV_CORRECT, {unlock, otp_valid}, 0);
        if (wrong) expect_ev(EV_WRONG, attempts_left, 0);
        if (deny && !pd && alarm)
          expect_ev(EV_LOCK, {otp_valid, attempts_left}, 0);
        if (deny && !pd && !alarm)
          expect_ev(EV_EXPIRE, cv, {otp_valid, attempts_left});
        if (!unlock && pu) expect_ev(EV_UNLOCK_END, cu, 0);
        if (!alarm && pa) expect_ev(EV_LOCK_END, ca, attempts_left);
        if (!deny && pd) expect_ev(EV_DENY_END, cd, 0);
        chk("correct_and_wrong", correct & wrong, 0);
        chk("unlock_and_alarm", unlock & alarm, 0);
        cv = otp_valid ? cv + 1 : 0;
        cu = unlock ? cu + 1 : 0;
        ca = alarm ? ca + 1 : 0;
        cd = deny ? cd + 1 : 0;
        pv = otp_valid; pu = unlock; pa = alarm; pd = deny;
        held = otp_value;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] wrong_code(input logic fixed,
                                             input logic [31:0] c);
    logic [31:0] r;
    r = fixed ? c : $urandom;
    if (r == cur_otp) r = r ^ 32'h1;
    return r;
  endfunction

  task automatic request();
    @(negedge clk);
    req_access = 1;
    cur_otp = lfsr_at(cyc);
    push(EV_ISSUE, cur_otp, 0);
    @(negedge clk);
    req_access = 0;
  endtask

  task automatic attempt(input logic [31:0] code, input int hold);
    @(negedge clk);
    user_entered_otp = code;
    enter_otp = 1;
    repeat (hold) @(negedge clk);
    enter_otp = 0;
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(1, GAP_MAX);
    req_access = 1'($urandom_range(0, 1));
    repeat (n) @(negedge clk);
    req_access = 0;
  endtask

  // strobes and requests while unlocked or locked out must be swallowed
  task automatic noise();
    @(negedge clk);
    req_access = 1; enter_otp = 1; user_entered_otp = cur_otp;
    @(negedge clk);
    enter_otp = 0;
    @(negedge clk);
    enter_otp = 1;
    @(negedge clk);
    req_access = 0; enter_otp = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((unlock || alarm || deny) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n >= 300, 0);
  endtask

  task automatic txn(input int n_wrong, input int hold1,
                     input logic fixed, input logic [31:0] code);
    request();
    for (int k = 1; k <= n_wrong; k++) begin
      push(EV_WRONG, 32'(TRIES - k), 0);
      if (k == TRIES) begin
        push(EV_LOCK, 0, 0);
        push(EV_LOCK_END, LO, TRIES);
        push(EV_DENY_END, LO, 0);
      end
      gap();
      attempt(wrong_code(fixed, code),
              k == 1 ? hold1 : $urandom_range(1, HOLD_MAX));
    end
    if (n_wrong < TRIES) begin
      push(EV_CORRECT, 2, 0);
      push(EV_UNLOCK_END, UL, 0);
      gap();
      attempt(cur_otp, $urandom_range(1, HOLD_MAX));
    end
    noise();
    wait_idle();
  endtask

  initial begin : stim
    rst = 1; req_access = 0; enter_otp = 0; user_entered_otp = '0;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("rst_otp_valid", otp_valid, 0);
    chk("rst_otp_value", otp_value, 0);
    chk("rst_pulses", {correct, wrong, unlock, deny, alarm}, 0);
    chk("rst_attempts", attempts_left, TRIES);

    txn(0, 1, 0, 0);
    txn(1, HOLD_LONG, 0, 0);
    txn(TRIES, 1, 1, 32'h000ABCDE);

`ifdef OTP_EXPIRY_EN
    request();
    push(EV_EXPIRE, TO, TRIES);
    push(EV_DENY_END, 1, 0);
    repeat (TO + 5) @(negedge clk);
    attempt(cur_otp, 1);
    repeat (5) @(negedge clk);
    chk("expired_no_unlock", unlock, 0);
    chk("expired_attempts", attempts_left, TRIES);
`else
    request();
    repeat (TO + 10) @(negedge clk);
    chk("no_expiry_valid", otp_valid, 1);
    chk("no_expiry_deny", deny, 0);
    push(EV_CORRECT, 2, 0);
    push(EV_UNLOCK_END, UL, 0);
    attempt(cur_otp, 1);
    wait_idle();
`endif

    for (int t = 0; t < 20; t++)
      txn($urandom_range(0, TRIES), $urandom_range(1, HOLD_MAX), 0, 0);

    request();
    push(EV_CORRECT, 2, 0);
    push(EV_UNLOCK_END, UL, 0);
    attempt(cur_otp, 1);
    repeat (4) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_unlock", unlock, 0);
    chk("midrst_valid", otp_valid, 0);
    chk("midrst_attempts", attempts_left, TRIES);
    sb.delete();
    @(negedge clk);
    #2 rst = 0;
    req_access = 1;
    cur_otp = SEED;
    push(EV_ISSUE, SEED, 0);
    @(negedge clk);
    req_access = 0;
    push(EV_CORRECT, 2, 0);
    push(EV_UNLOCK_END, UL, 0);
    attempt(cur_otp, 2);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
